// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_param
// Brief    : Parametrised UART transmitter fed from a small input FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_param #(
  parameter int BAUD_DIV   = 10416,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid_in,
  input  logic [DATA_BITS-1:0]          data_storing,
  output logic                          ready_out,
  output logic                          one_by_one_bit,
  output logic                          my9600clk,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int c_aw = $clog2(FIFO_DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam int c_bw = $clog2(BAUD_DIV);
  localparam logic [c_bw-1:0] c_baud_last = c_bw'(BAUD_DIV - 1);
  localparam logic [3:0]      c_data_last = 4'(DATA_BITS - 1);
  localparam logic [3:0]      c_stop_last = 4'(STOP_BITS - 1);
  localparam logic [c_cw-1:0] c_full      = c_cw'(FIFO_DEPTH);
  localparam logic            c_odd       = (PARITY == 2);

  generate
    if (BAUD_DIV < 2) begin : g_bad_baud
      $error("uart_tx_param: BAUD_DIV must be 2 or more");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
      $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_param: FIFO_DEPTH must be a power of 2, 2 or more");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [DATA_BITS-1:0]   r_shift, w_shift_nxt;
  logic                   r_parity, w_parity_nxt;
  logic [3:0]             r_bit, w_bit_nxt;
  logic [c_bw-1:0]        r_baud;
  logic                   r_tx, w_tx_nxt;
  logic                   r_busy;
  logic                   w_tick;

  logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
  logic [c_aw-1:0]        r_wr, r_rd;
  logic [c_cw-1:0]        r_count;
  logic                   w_push, w_pop, w_not_empty;
  logic [DATA_BITS-1:0]   w_head;
  logic                   w_par_load;

  assign ready_out   = (r_count != c_full);
  assign w_not_empty = (r_count != '0);
  assign w_push      = valid_in && ready_out;
  assign w_head      = r_mem[r_rd];
  assign w_par_load  = (^w_head) ^ c_odd;
  assign w_tick      = (r_state != S_IDLE) && (r_baud == c_baud_last);

  assign one_by_one_bit = r_tx;
  assign my9600clk      = w_tick;
  assign busy           = r_busy;
  assign fifo_count     = r_count;

  // Circular buffer; pointers wrap naturally because depth is a power of 2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= data_storing;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_parity_nxt = r_parity;
    w_bit_nxt    = r_bit;
    w_pop        = 1'b0;
    w_tx_nxt     = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_not_empty) w_pop = 1'b1;
      end
      S_START: begin
        if (w_tick) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = '0;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit == c_data_last) begin
            w_bit_nxt   = '0;
            w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            w_bit_nxt = r_bit + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_state_nxt = S_STOP;
          w_bit_nxt   = '0;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (r_bit == c_stop_last) begin
            if (w_not_empty) w_pop = 1'b1;
            else             w_state_nxt = S_IDLE;
          end else begin
            w_bit_nxt = r_bit + 4'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // A pop always loads a fresh frame, whether from IDLE or end of STOP.
    if (w_pop) begin
      w_state_nxt  = S_START;
      w_shift_nxt  = w_head;
      w_parity_nxt = w_par_load;
      w_bit_nxt    = '0;
    end

    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
      S_PARITY: w_tx_nxt = w_parity_nxt;
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_bit    <= '0;
      r_baud   <= '0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_parity <= w_parity_nxt;
      r_bit    <= w_bit_nxt;
      r_baud   <= (r_state == S_IDLE || w_tick) ? '0 : r_baud + 1'b1;
      r_tx     <= w_tx_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
    end
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter, the successor to the fixed 8N1/9600 CEP transmitter. It serialises words from a small input FIFO onto a single TX line. Data width, parity mode, stop-bit count, baud divisor and FIFO depth are all configurable. Upstream logic loads words through a valid/ready handshake. A per-bit baud tick is exported for debug and bench alignment.

Parameters:
BAUD_DIV, 10416, clk cycles per bit (100 MHz / 9600); legal range 2 and up
DATA_BITS, 8, payload bits per frame; legal 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2 stop bits
FIFO_DEPTH, 4, input FIFO entries; power of 2, 2 and up

Ports:
clk  input  1  system clock; all logic on the rising edge
reset  input  1  asynchronous, active-low reset
valid_in  input  1  upstream word valid
data_storing  input  DATA_BITS  word to transmit; sampled when valid_in and ready_out are both high
ready_out  output  1  FIFO can accept a word
one_by_one_bit  output  1  serial TX line; idles high
my9600clk  output  1  one-cycle pulse at the end of every bit period
busy  output  1  a frame is in progress
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (reset low, asynchronous): one_by_one_bit=1, ready_out=1, busy=0, my9600clk=0, fifo_count=0; FIFO emptied; FSM=IDLE; baud counter=0.
- Reset mid-frame: the line returns high immediately and the frame is aborted; any partial frame is not resumed after release.
- Handshake:
  - ready_out = (fifo_count != FIFO_DEPTH), combinational from the count.
  - A push occurs on the rising edge when valid_in && ready_out. data_storing is ignored otherwise.
  - Push and pop on the same edge leave fifo_count unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: line high, busy=0, baud counter held at 0. If the FIFO is non-empty on an edge: pop the head into the shift register, go to START, drive the line low.
  - START: line 0 for one bit period, then go to DATA with bit index 0.
  - DATA: line = shift[0], LSB first. Shift right at each bit end. After DATA_BITS bits, go to PARITY if PARITY != 0, else STOP.
  - PARITY: line = XOR of the payload (even mode) or its inverse (odd mode), computed over DATA_BITS bits at load time. Lasts one bit period, then go to STOP.
  - STOP: line 1 for STOP_BITS bit periods. At the end, if the FIFO is non-empty, pop and enter START on the same edge (no idle gap between frames). Otherwise go to IDLE.
- Bit timing:
  - The baud counter restarts at 0 on frame load and counts 0..BAUD_DIV-1.
  - my9600clk is high exactly in the cycle where the counter = BAUD_DIV-1 and the FSM is not IDLE. Bit and state transitions take place on the following edge.
  - Every bit lasts exactly BAUD_DIV cycles.
  - Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) × BAUD_DIV cycles.
- Latency: if a word is pushed at edge E into an empty FIFO while in IDLE, the line falls at edge E+1.
- busy = (state != IDLE). It is registered alongside the state.
- The FIFO is a circular buffer with wrap-around pointers. Full/empty status is derived from the count.
- Illegal parameter values are rejected by an elaboration-time assertion.

Test Plan:
- 8N1 with BAUD_DIV=4, push 0x49: line sequence 0,1,0,0,1,0,0,1,0,1, each bit 4 cycles. Frame lasts 40 cycles, my9600clk pulses 10 times, busy is high for exactly 40 cycles.
- PARITY=1 then PARITY=2, push 0x49 (three ones): parity bit is 1 for even and 0 for odd. Frame is 44 cycles.
- DATA_BITS=7, STOP_BITS=2, BAUD_DIV=4, push 0x55: 7 data bits 1,0,1,0,1,0,1, then 8 cycles high. Frame is 40 cycles.
- FIFO_DEPTH=4, hold valid_in with words 0x01..0x06:
  - 5 words are accepted, with ready_out low once fifo_count=4.
  - ready_out reasserts one cycle after each pop.
  - Frames run back-to-back with no idle high between the stop bit and the next start bit.
- Push on the same edge as a pop (FIFO at count 2, frame end): fifo_count stays 2, and the data order is preserved across pointer wrap-around.
- Assert reset mid-DATA: the line goes high and fifo_count goes to 0 without waiting for a clock edge. After release, a push of 0xA5 produces a clean, correct frame.
